// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared widths and FSM state encoding for the fetch controller.
package instr_fetch_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;
endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: saturating wait counter; expired flags the TIMEOUT-th enabled cycle.
module fetch_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] count;
    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (enable && count != W'(TIMEOUT))
            count <= count + 1'b1;
    end
    assign expired = enable && count >= W'(TIMEOUT - 1);
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch controller between PC and memory.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] pc_value,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_in,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_err
);
    state_t state, next;
    logic [ADDR_W-1:0] fetch_addr;
    logic timer_en, timer_clr, expired;

    fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clr),
        .enable (timer_en),
        .expired(expired)
    );

    always_comb begin
        pc_load     = redirect_valid;
        pc_in       = redirect_valid ? redirect_addr : '0;
        pc_inc      = state == WAIT && mem_rvalid && !redirect_valid;
        mem_rd_en   = state == REQ && !redirect_valid;
        mem_addr    = mem_rd_en ? pc_value : '0;
        instr_valid = state == HOLD;
        timer_en    = state == WAIT || state == DRAIN;
        timer_clr   = !timer_en || (state == WAIT && redirect_valid);
        next        = state;
        case (state)
            IDLE:    next = fetch_en ? REQ : IDLE;
            REQ:     next = redirect_valid ? REQ : WAIT;
            // a response landing with the redirect has already retired the read
            WAIT:    next = redirect_valid ? (mem_rvalid ? REQ : DRAIN) :
                            mem_rvalid ? HOLD : expired ? IDLE : WAIT;
            HOLD:    next = redirect_valid ? REQ :
                            instr_ready ? (fetch_en ? REQ : IDLE) : HOLD;
            DRAIN:   next = mem_rvalid ? REQ : expired ? IDLE : DRAIN;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fetch_addr <= '0;
            instr      <= '0;
            instr_addr <= '0;
            fetch_err  <= 1'b0;
        end else begin
            state <= next;
            if (state == REQ)
                fetch_addr <= pc_value;
            if (pc_inc) begin
                instr      <= mem_rdata;
                instr_addr <= fetch_addr;
            end
            // only a timer expiry leaves WAIT/DRAIN for IDLE
            if (timer_en && next == IDLE)
                fetch_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table vectors, directed corner sequences and random traffic vs a transaction model.
module tb_instr_fetch;
    localparam int T = 4;
    logic clk = 1'b0;
    logic reset, fetch_en, mem_rvalid, redirect_valid, instr_ready;
    logic [15:0] pc_value, mem_rdata, redirect_addr;
    logic pc_inc, pc_load, mem_rd_en, instr_valid, fetch_err;
    logic [15:0] pc_in, mem_addr, instr, instr_addr;

    instr_fetch #(.TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_value(pc_value),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_in(pc_in),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .instr(instr), .instr_addr(instr_addr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    // transaction-level view: pending request, read in flight (maybe doomed), instruction held
    bit m_req, m_out, m_drop, m_have, m_err;
    int m_wait;
    logic [15:0] m_instr = 16'h0, m_iaddr = 16'h0, m_faddr = 16'h0;
    bit s_rd, s_inc, s_load;

    typedef struct {
        logic fen; logic [15:0] pc; logic rv; logic [15:0] rd; logic rdy;
        logic e_rd; logic [15:0] e_addr; logic e_inc; logic e_valid;
        logic [15:0] e_instr; logic [15:0] e_iaddr;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit e_rd, e_inc;
        e_rd  = m_req && !redirect_valid;
        e_inc = m_out && !m_drop && mem_rvalid && !redirect_valid;
        chk("pc_load", pc_load, redirect_valid);
        chk("pc_in", pc_in, redirect_valid ? redirect_addr : 16'h0);
        chk("pc_inc", pc_inc, e_inc);
        chk("mem_rd_en", mem_rd_en, e_rd);
        chk("mem_addr", mem_addr, e_rd ? pc_value : 16'h0);
        chk("instr_valid", instr_valid, m_have);
        chk("instr", instr, m_instr);
        chk("instr_addr", instr_addr, m_iaddr);
        chk("fetch_err", fetch_err, m_err);
        s_rd = mem_rd_en; s_inc = pc_inc; s_load = pc_load;
    endtask

    task automatic model_update();
        if (reset) begin
            m_req = 0; m_out = 0; m_drop = 0; m_have = 0; m_err = 0; m_wait = 0;
            m_instr = 16'h0; m_iaddr = 16'h0; m_faddr = 16'h0;
        end else if (m_req) begin
            if (!redirect_valid) begin
                m_req = 0; m_out = 1; m_wait = 0; m_faddr = pc_value;
            end
        end else if (m_out) begin
            if (!m_drop && redirect_valid) begin
                if (mem_rvalid) begin m_out = 0; m_req = 1; end
                else begin m_drop = 1; m_wait = 0; end
            end else if (mem_rvalid) begin
                m_out = 0;
                if (m_drop) begin m_drop = 0; m_req = 1; end
                else begin m_have = 1; m_instr = mem_rdata; m_iaddr = m_faddr; end
            end else if (m_wait + 1 >= T) begin
                m_err = 1; m_out = 0; m_drop = 0;
            end else m_wait++;
        end else if (m_have) begin
            if (redirect_valid) begin m_have = 0; m_req = 1; end
            else if (instr_ready) begin m_have = 0; m_req = fetch_en; end
        end else if (fetch_en) m_req = 1;
    endtask

    task automatic drive(input logic fen, input logic [15:0] pc, input logic rv, input logic [15:0] rd,
                         input logic rdr, input logic [15:0] ra, input logic rdy);
        fetch_en = fen; pc_value = pc; mem_rvalid = rv; mem_rdata = rd;
        redirect_valid = rdr; redirect_addr = ra; instr_ready = rdy;
        #2;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic cyc(input logic fen, input logic [15:0] pc, input logic rv, input logic [15:0] rd,
                       input logic rdr, input logic [15:0] ra, input logic rdy);
        drive(fen, pc, rv, rd, rdr, ra, rdy);
        tick();
    endtask

    initial begin
        logic [15:0] pc;
        bit pend;
        int cnt;
        tbl[0]  = '{1'b1, 16'h0010, 1'b0, 16'h0,    1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 16'h0,    16'h0};
        tbl[1]  = '{1'b1, 16'h0010, 1'b0, 16'h0,    1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0,    16'h0};
        tbl[2]  = '{1'b1, 16'h0010, 1'b1, 16'hA010, 1'b0, 1'b0, 16'h0,    1'b1, 1'b0, 16'h0,    16'h0};
        tbl[3]  = '{1'b1, 16'h0011, 1'b0, 16'h0,    1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 16'hA010, 16'h0010};
        tbl[4]  = '{1'b1, 16'h0011, 1'b0, 16'h0,    1'b0, 1'b1, 16'h0011, 1'b0, 1'b0, 16'hA010, 16'h0010};
        tbl[5]  = '{1'b1, 16'h0011, 1'b1, 16'hA011, 1'b0, 1'b0, 16'h0,    1'b1, 1'b0, 16'hA010, 16'h0010};
        tbl[6]  = '{1'b1, 16'h0012, 1'b0, 16'h0,    1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 16'hA011, 16'h0011};
        tbl[7]  = '{1'b1, 16'h0012, 1'b0, 16'h0,    1'b0, 1'b1, 16'h0012, 1'b0, 1'b0, 16'hA011, 16'h0011};
        tbl[8]  = '{1'b1, 16'h0012, 1'b1, 16'hA012, 1'b0, 1'b0, 16'h0,    1'b1, 1'b0, 16'hA011, 16'h0011};
        tbl[9]  = '{1'b0, 16'h0013, 1'b0, 16'h0,    1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 16'hA012, 16'h0012};
        tbl[10] = '{1'b0, 16'h0013, 1'b0, 16'h0,    1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 16'hA012, 16'h0012};

        reset = 1'b1; fetch_en = 0; pc_value = 0; mem_rvalid = 0; mem_rdata = 0;
        redirect_valid = 0; redirect_addr = 0; instr_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // straight-line fetch with a one-cycle memory
        foreach (tbl[i]) begin
            drive(tbl[i].fen, tbl[i].pc, tbl[i].rv, tbl[i].rd, 1'b0, 16'h0, tbl[i].rdy);
            chk($sformatf("tbl%0d_rd_en", i), mem_rd_en, tbl[i].e_rd);
            chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_inc", i), pc_inc, tbl[i].e_inc);
            chk($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
            chk($sformatf("tbl%0d_iaddr", i), instr_addr, tbl[i].e_iaddr);
            tick();
        end

        // backpressure in HOLD
        cyc(1, 16'h0020, 0, 0, 0, 0, 0);
        cyc(1, 16'h0020, 0, 0, 0, 0, 0);
        cyc(1, 16'h0020, 1, 16'hBEEF, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 16'h0021, 0, 0, 0, 0, 0);
            chk("bp_instr", instr, 16'hBEEF);
            chk("bp_iaddr", instr_addr, 16'h0020);
            chk("bp_valid", instr_valid, 1'b1);
            chk("bp_rd_en", mem_rd_en, 1'b0);
            tick();
        end
        cyc(1, 16'h0021, 0, 0, 0, 0, 1);

        // redirect while waiting; the late response must be dropped
        cyc(1, 16'h0021, 0, 0, 0, 0, 0);
        drive(1, 16'h0021, 0, 0, 1, 16'h0400, 0);
        chk("rw_load", pc_load, 1'b1);
        chk("rw_pc_in", pc_in, 16'h0400);
        chk("rw_inc", pc_inc, 1'b0);
        tick();
        drive(1, 16'h0400, 1, 16'hDEAD, 0, 0, 0);
        chk("rw_late_inc", pc_inc, 1'b0);
        tick();
        drive(1, 16'h0400, 0, 0, 0, 0, 0);
        chk("rw_next_rd", mem_rd_en, 1'b1);
        chk("rw_next_addr", mem_addr, 16'h0400);
        tick();

        // redirect in the same cycle as the response
        drive(1, 16'h0400, 1, 16'hCAFE, 1, 16'h0800, 1);
        chk("co_inc", pc_inc, 1'b0);
        chk("co_load", pc_load, 1'b1);
        tick();
        drive(1, 16'h0800, 0, 0, 0, 0, 1);
        chk("co_next_addr", mem_addr, 16'h0800);
        chk("co_valid", instr_valid, 1'b0);
        tick();
        cyc(1, 16'h0800, 1, 16'h5A5A, 0, 0, 1);
        drive(0, 16'h0801, 0, 0, 0, 0, 1);
        chk("co_instr", instr, 16'h5A5A);
        chk("co_iaddr", instr_addr, 16'h0800);
        tick();

        // timeout with no response
        cyc(1, 16'h0030, 0, 0, 0, 0, 0);
        cyc(0, 16'h0030, 0, 0, 0, 0, 0);
        for (int k = 0; k < T; k++) begin
            drive(0, 16'h0030, 0, 0, 0, 0, 0);
            chk("to_err_pending", fetch_err, 1'b0);
            tick();
        end
        drive(0, 16'h0030, 0, 0, 0, 0, 0);
        chk("to_err", fetch_err, 1'b1);
        chk("to_valid", instr_valid, 1'b0);
        chk("to_idle_rd", mem_rd_en, 1'b0);
        tick();
        reset = 1'b1;
        cyc(0, 16'h0030, 0, 0, 0, 0, 0);
        reset = 1'b0;
        drive(0, 16'h0030, 0, 0, 0, 0, 0);
        chk("to_clr", fetch_err, 1'b0);
        tick();

        // fetch one instruction, then reset during WAIT with a stale response after
        cyc(1, 16'h0040, 0, 0, 0, 0, 0);
        cyc(1, 16'h0040, 0, 0, 0, 0, 0);
        cyc(1, 16'h0040, 1, 16'h7777, 0, 0, 1);
        cyc(1, 16'h0041, 0, 0, 0, 0, 1);
        cyc(1, 16'h0041, 0, 0, 0, 0, 1);
        cyc(1, 16'h0041, 0, 0, 0, 0, 1);
        reset = 1'b1;
        cyc(0, 16'h0041, 0, 0, 0, 0, 1);
        reset = 1'b0;
        drive(0, 16'h0041, 1, 16'h1234, 0, 0, 1);
        chk("rs_valid", instr_valid, 1'b0);
        chk("rs_inc", pc_inc, 1'b0);
        chk("rs_instr", instr, 16'h0);
        chk("rs_iaddr", instr_addr, 16'h0);
        chk("rs_addr", mem_addr, 16'h0);
        tick();
        drive(0, 16'h0041, 0, 0, 0, 0, 1);
        chk("rs_stale_instr", instr, 16'h0);
        chk("rs_stale_valid", instr_valid, 1'b0);
        tick();

        // random traffic with a variable-latency responder and a bench-side PC
        pc = 16'($urandom);
        pend = 0; cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            bit rv;
            reset = ($urandom_range(0, 249) == 0);
            rv = (pend && cnt == 0) || ($urandom_range(0, 31) == 0);
            drive($urandom_range(0, 9) != 0, pc, rv, 16'($urandom),
                  $urandom_range(0, 19) == 0, 16'($urandom), $urandom_range(0, 9) < 7);
            tick();
            if (rv) pend = 0;
            else if (pend) cnt--;
            if (s_rd) begin
                pend = 1;
                cnt = ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, 2);
            end
            if (reset) pc = 16'($urandom);
            else if (s_load) pc = redirect_addr;
            else if (s_inc) pc = pc + 16'd1;
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
